// File: rtl/line_mem_responder_if.sv
// Line-refill bus between the data cache (master) and the memory responder (slave).
// Latency: none, wiring only.
// Backpressure: requests are level-held by the master until the slave pulses done.
interface line_mem_responder_if;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [31:0]  wb_addr;
    logic [255:0] line_wdata;
    logic         ld_we;
    logic [31:0]  ld_addr;
    logic [31:0]  ld_data;
    logic [255:0] line_rdata;
    logic         done;
    logic         busy;

    modport master (
        output mem_read, mem_write, mem_addr, wb_addr, line_wdata,
        output ld_we, ld_addr, ld_data,
        input  line_rdata, done, busy
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, wb_addr, line_wdata,
        input  ld_we, ld_addr, ld_data,
        output line_rdata, done, busy
    );
endinterface

// File: rtl/line_mem_responder.sv
// Reference memory servicing cache line fills/write-backs one 32-bit word per beat.
// Latency: done in cycle N*8*(1+BEAT_LAT)+1 after acceptance (N = 1 or 2 phases).
// Backpressure: none; requester holds mem_read/mem_write until the done pulse.
module line_mem_responder #(
    parameter int ADDR_BITS = 16,
    parameter int BEAT_LAT  = 0
) (
    input logic           i_clk,
    input logic           i_rst,
    line_mem_responder_if.slave bus
);

    localparam int         BASE_BITS = ADDR_BITS - 3;
    localparam logic [3:0] LAT       = 4'(BEAT_LAT);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

    state_t                 r_state;
    logic [3:0]             r_wait;
    logic [2:0]             r_beat;
    logic [BASE_BITS-1:0]   r_wb_base;
    logic [BASE_BITS-1:0]   r_fill_base;
    logic [7:0][31:0]       r_wdata;
    logic                   r_rd_pend;
    logic [7:0][31:0]       r_rdata;
    logic                   r_done;
    logic                   r_busy;

    // Backing store is deliberately not reset so preloaded contents survive RST.
    logic [31:0]            r_mem [0:(1<<ADDR_BITS)-1];

    logic                   w_beat_end;
    logic [ADDR_BITS-1:0]   w_wb_idx;
    logic [ADDR_BITS-1:0]   w_fill_idx;
    logic [ADDR_BITS-1:0]   w_ld_idx;
    logic [31:0]            w_rd_word;
    logic                   w_store_we;
    logic [ADDR_BITS-1:0]   w_store_idx;
    logic [31:0]            w_store_dat;
    logic                   w_unused_bits;

    assign w_beat_end = (r_wait == LAT);
    assign w_wb_idx   = {r_wb_base, r_beat};
    assign w_fill_idx = {r_fill_base, r_beat};
    assign w_ld_idx   = bus.ld_addr[ADDR_BITS+1:2];
    assign w_rd_word  = r_mem[w_fill_idx];

    // Only one writer per cycle: preload in IDLE, write-back beats in WB.
    assign w_store_we  = !i_rst && (((r_state == S_IDLE) && bus.ld_we) ||
                                    ((r_state == S_WB) && w_beat_end));
    assign w_store_idx = (r_state == S_WB) ? w_wb_idx : w_ld_idx;
    assign w_store_dat = (r_state == S_WB) ? r_wdata[r_beat] : bus.ld_data;

    // Address bits outside the word index are aliased away.
    assign w_unused_bits = ^{bus.mem_addr[31:ADDR_BITS+2], bus.mem_addr[4:0],
                             bus.wb_addr[31:ADDR_BITS+2],  bus.wb_addr[4:0],
                             bus.ld_addr[31:ADDR_BITS+2],  bus.ld_addr[1:0]};

    assign bus.line_rdata = r_rdata;
    assign bus.done       = r_done;
    assign bus.busy       = r_busy;

    // Store write port: preload or write-back beat.
    always_ff @(posedge i_clk) begin
        if (w_store_we) begin
            r_mem[w_store_idx] <= w_store_dat;
        end
    end

    // Request FSM: acceptance, WB beats, FILL beats, done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_wait      <= 4'd0;
            r_beat      <= 3'd0;
            r_wb_base   <= '0;
            r_fill_base <= '0;
            r_wdata     <= '0;
            r_rd_pend   <= 1'b0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wait <= 4'd0;
                    r_beat <= 3'd0;
                    if (bus.mem_write) begin
                        r_wb_base   <= bus.wb_addr[ADDR_BITS+1:5];
                        r_fill_base <= bus.mem_addr[ADDR_BITS+1:5];
                        r_wdata     <= bus.line_wdata;
                        r_rd_pend   <= bus.mem_read;
                        r_busy      <= 1'b1;
                        r_state     <= S_WB;
                    end else if (bus.mem_read) begin
                        r_fill_base <= bus.mem_addr[ADDR_BITS+1:5];
                        r_rd_pend   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_FILL;
                    end
                end
                S_WB: begin
                    if (w_beat_end) begin
                        r_wait <= 4'd0;
                        r_beat <= r_beat + 3'd1;
                        if (r_beat == 3'd7) begin
                            if (r_rd_pend) begin
                                r_state <= S_FILL;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                S_FILL: begin
                    if (w_beat_end) begin
                        r_rdata[r_beat] <= w_rd_word;
                        r_wait          <= 4'd0;
                        r_beat          <= r_beat + 3'd1;
                        if (r_beat == 3'd7) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: two instances (BEAT_LAT 0 and 3) behind a select.
// Latency: checks done cycle, busy window and returned line per request.
// Backpressure: requester drops its request at the done-sampling edge unless holding deliberately.
module tb_line_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    int           sel;
    logic         t_read, t_write, t_ld_we;
    logic [31:0]  t_maddr, t_waddr, t_ld_addr, t_ld_data;
    logic [255:0] t_wdata;

    line_mem_responder_if if0 ();
    line_mem_responder_if if3 ();

    assign if0.mem_read   = (sel == 0) && t_read;
    assign if0.mem_write  = (sel == 0) && t_write;
    assign if0.mem_addr   = t_maddr;
    assign if0.wb_addr    = t_waddr;
    assign if0.line_wdata = t_wdata;
    assign if0.ld_we      = (sel == 0) && t_ld_we;
    assign if0.ld_addr    = t_ld_addr;
    assign if0.ld_data    = t_ld_data;

    assign if3.mem_read   = (sel == 1) && t_read;
    assign if3.mem_write  = (sel == 1) && t_write;
    assign if3.mem_addr   = t_maddr;
    assign if3.wb_addr    = t_waddr;
    assign if3.line_wdata = t_wdata;
    assign if3.ld_we      = (sel == 1) && t_ld_we;
    assign if3.ld_addr    = t_ld_addr;
    assign if3.ld_data    = t_ld_data;

    logic         w_done, w_busy;
    logic [255:0] w_rdata;
    assign w_done  = (sel == 1) ? if3.done       : if0.done;
    assign w_busy  = (sel == 1) ? if3.busy       : if0.busy;
    assign w_rdata = (sel == 1) ? if3.line_rdata : if0.line_rdata;

    line_mem_responder #(.ADDR_BITS(16), .BEAT_LAT(0)) u_dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if0.slave)
    );

    line_mem_responder #(.ADDR_BITS(16), .BEAT_LAT(3)) u_dut3 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if3.slave)
    );

    typedef struct {
        int          sel;
        logic        rd;
        logic        wr;
        logic [31:0] maddr;
        logic [31:0] waddr;
        logic [31:0] wpat;
        int          ld_cyc;
        int          exp_cyc;
        logic [31:0] exp_pat;
    } vec_t;

    typedef struct {
        int           cyc;
        logic [255:0] line;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    localparam logic [31:0] PAT_A = 32'hA000_0000;
    localparam logic [31:0] PAT_B = 32'hB000_0000;
    localparam logic [31:0] PAT_C = 32'hC000_0000;
    localparam logic [31:0] PAT_D = 32'hD000_0000;

    function automatic logic [255:0] mkline(input logic [31:0] p);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = p + 32'(k);
        return l;
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic preload(input int s, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = s; t_ld_we = 1'b1; t_ld_addr = a; t_ld_data = d;
        @(negedge clk);
        t_ld_we = 1'b0;
    endtask

    // Called right after the acceptance edge; returns at the negedge of the done cycle.
    task automatic wait_done(input int ld_cyc, input logic [31:0] ld_a, output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        while (!ok && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                t_maddr = t_maddr ^ 32'h100;
                t_waddr = t_waddr ^ 32'h100;
                t_wdata = ~t_wdata;
            end
            if (cyc == ld_cyc) begin
                t_ld_we = 1'b1; t_ld_addr = ld_a; t_ld_data = 32'hDEAD_BEEF;
            end else begin
                t_ld_we = 1'b0;
            end
            chk("busy_in_service", 256'(w_busy), 256'(1'b1));
            if (w_done) ok = 1'b1;
        end
        t_ld_we = 1'b0;
        if (!ok) begin
            n_chk++; n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles, required one", cyc);
        end
    endtask

    task automatic check_result(input int cyc);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL scoreboard_empty: got done with no expectation, required a queued entry");
        end else begin
            e = sb_q.pop_front();
            chk("done_cycle", 256'(cyc), 256'(e.cyc));
            chk("line_rdata", w_rdata, e.line);
        end
    endtask

    task automatic run_req(input vec_t v);
        exp_t e;
        int   cyc;
        bit   ok;
        @(negedge clk);
        sel = v.sel;
        t_read = v.rd; t_write = v.wr;
        t_maddr = v.maddr; t_waddr = v.waddr; t_wdata = mkline(v.wpat);
        e.cyc = v.exp_cyc; e.line = mkline(v.exp_pat);
        sb_q.push_back(e);
        @(posedge clk);
        wait_done(v.ld_cyc, v.maddr + 32'h8, cyc, ok);
        t_read = 1'b0; t_write = 1'b0;
        if (ok) check_result(cyc);
        else void'(sb_q.pop_front());
        @(negedge clk);
        chk("idle_busy", 256'(w_busy), 256'(1'b0));
        chk("idle_done", 256'(w_done), 256'(1'b0));
    endtask

    vec_t vt[10];

    initial begin
        int   cyc;
        bit   ok;
        exp_t e;

        // sel, rd, wr, maddr, waddr, wpat, ld_cyc, exp_cyc, exp_pat
        vt[0] = '{0, 1'b1, 1'b0, 32'h0000_1004, 32'h0,         32'h0, 0,  9, PAT_A};
        vt[1] = '{0, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, PAT_B, 0, 17, PAT_A};
        vt[2] = '{0, 1'b1, 1'b0, 32'h0000_2000, 32'h0,         32'h0, 0,  9, PAT_B};
        vt[3] = '{0, 1'b1, 1'b1, 32'h0000_3000, 32'h0000_3000, PAT_C, 0, 17, PAT_C};
        vt[4] = '{0, 1'b1, 1'b0, 32'h0004_1000, 32'h0,         32'h0, 0,  9, PAT_A};
        vt[5] = '{0, 1'b0, 1'b1, 32'h0,         32'h0000_5000, PAT_D, 0,  9, PAT_A};
        vt[6] = '{0, 1'b1, 1'b0, 32'h0000_5000, 32'h0,         32'h0, 0,  9, PAT_D};
        vt[7] = '{1, 1'b1, 1'b0, 32'h0000_1000, 32'h0,         32'h0, 0, 33, PAT_A};
        vt[8] = '{0, 1'b1, 1'b0, 32'h0000_1000, 32'h0,         32'h0, 3,  9, PAT_A};
        vt[9] = '{0, 1'b1, 1'b0, 32'h0000_1000, 32'h0,         32'h0, 0,  9, PAT_A};

        rst = 1'b1; sel = 0;
        t_read = 1'b0; t_write = 1'b0; t_ld_we = 1'b0;
        t_maddr = '0; t_waddr = '0; t_ld_addr = '0; t_ld_data = '0; t_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            chk("reset_busy",  256'(w_busy), 256'(1'b0));
            chk("reset_done",  256'(w_done), 256'(1'b0));
            chk("reset_rdata", w_rdata, 256'(0));
        end

        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 8; k++)
                preload(s, 32'h1000 + 32'(4 * k), PAT_A + 32'(k));

        for (int i = 0; i < 10; i++) run_req(vt[i]);

        // Reset in cycle 4 of a fill aborts it and clears outputs.
        @(negedge clk);
        sel = 0; t_read = 1'b1; t_maddr = 32'h0000_2000;
        @(posedge clk);
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", 256'(w_busy), 256'(1'b1));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy",  256'(w_busy), 256'(1'b0));
        chk("rst_mid_done",  256'(w_done), 256'(1'b0));
        chk("rst_mid_rdata", w_rdata, 256'(0));
        rst = 1'b0; t_read = 1'b0;
        run_req(vt[9]);

        // Request held one cycle past done is serviced again.
        @(negedge clk);
        sel = 0; t_read = 1'b1; t_write = 1'b0; t_maddr = 32'h0000_2000;
        e.cyc = 9; e.line = mkline(PAT_B); sb_q.push_back(e);
        @(posedge clk);
        wait_done(0, 32'h0, cyc, ok);
        if (ok) check_result(cyc); else void'(sb_q.pop_front());
        t_maddr = 32'h0000_2000;
        @(negedge clk);
        chk("held_gap_busy", 256'(w_busy), 256'(1'b0));
        chk("held_gap_done", 256'(w_done), 256'(1'b0));
        e.cyc = 9; e.line = mkline(PAT_B); sb_q.push_back(e);
        @(posedge clk);
        wait_done(0, 32'h0, cyc, ok);
        t_read = 1'b0;
        if (ok) check_result(cyc); else void'(sb_q.pop_front());
        @(negedge clk);
        chk("held_end_busy", 256'(w_busy), 256'(1'b0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
